// File: rtl/key_assembler.sv
// Threefish-1024 extended key assembler.
// Collects sixteen 64-bit key words over a valid/ready stream, folds each word
// into the running parity word (seeded with C240) and presents the 17-word key
// to the key schedule through a valid/ready handoff.
module key_assembler #(
    parameter int                WORDS        = 16,
    parameter int                WORD_W       = 64,
    parameter logic [WORD_W-1:0] PARITY_CONST = 64'h1BD11BDAA9FC1A22
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          clear_i,
    input  logic [WORD_W-1:0]             word_i,
    input  logic                          word_valid_i,
    output logic                          word_ready_o,
    output logic [(WORDS+1)*WORD_W-1:0]   key_o,
    output logic                          key_valid_o,
    input  logic                          key_ready_i,
    output logic [4:0]                    word_idx_o
);

    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t             state_reg,  state_next;
    logic [IDX_W-1:0]   idx_reg,    idx_next;
    logic [WORD_W-1:0]  parity_reg, parity_next;
    logic               wr_en;
    logic [WORD_W-1:0]  word_reg [WORDS];

    // State, slot index and running parity registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            parity_reg <= PARITY_CONST;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            parity_reg <= parity_next;
        end
    end

    // Next-state logic; clear wins over accepts and key consumption outside IDLE.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        parity_next = parity_reg;
        wr_en       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                state_next = FILL;
            end
            FILL: begin
                if (clear_i) begin
                    idx_next    = '0;
                    parity_next = PARITY_CONST;
                end else if (word_valid_i) begin
                    wr_en       = 1'b1;
                    parity_next = parity_reg ^ word_i;
                    if (idx_reg == LAST_IDX) begin
                        // Park the index at 0; FULL reports 16 through the decode below.
                        idx_next   = '0;
                        state_next = FULL;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            FULL: begin
                if (clear_i || key_ready_i) begin
                    state_next  = FILL;
                    idx_next    = '0;
                    parity_next = PARITY_CONST;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One register per key word; only the slot addressed by the index loads.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    word_reg[gi] <= '0;
                end else if (wr_en && (idx_reg == IDX_W'(gi))) begin
                    word_reg[gi] <= word_i;
                end
            end
            assign key_o[gi*WORD_W +: WORD_W] = word_reg[gi];
        end
    endgenerate

    // The parity register is always visible as the top key word.
    assign key_o[WORDS*WORD_W +: WORD_W] = parity_reg;

    // Handshake and index outputs decode registered state only.
    always_comb begin
        word_ready_o = (state_reg == FILL);
        key_valid_o  = (state_reg == FULL);
        word_idx_o   = (state_reg == FULL) ? 5'(WORDS) : 5'(idx_reg);
    end

endmodule

// File: tb/tb_key_assembler.sv
// Self-checking bench for key_assembler: directed scenarios plus randomized keys
// compared against a word-list / XOR-fold reference model.
module tb_key_assembler;

    localparam logic [63:0] C240 = 64'h1BD11BDAA9FC1A22;
    typedef logic [63:0] words_t [16];

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [63:0]   word;
    logic          word_valid;
    logic          word_ready;
    logic [1087:0] key;
    logic          key_valid;
    logic          key_ready;
    logic [4:0]    word_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_assembler dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .clear_i      (clear),
        .word_i       (word),
        .word_valid_i (word_valid),
        .word_ready_o (word_ready),
        .key_o        (key),
        .key_valid_o  (key_valid),
        .key_ready_i  (key_ready),
        .word_idx_o   (word_idx)
    );

    // Reference: key words in order, parity word = C240 xor all key words.
    function automatic logic [1087:0] model_key(input words_t w);
        logic [63:0]   p;
        logic [1087:0] k;
        p = C240;
        k = '0;
        for (int i = 0; i < 16; i++) begin
            p = p ^ w[i];
            k[64*i +: 64] = w[i];
        end
        k[1087:1024] = p;
        return k;
    endfunction

    function automatic words_t rand_words();
        words_t w;
        for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
        return w;
    endfunction

    // Called at a falling edge; returns at the falling edge after the word is taken.
    task automatic push_word(input logic [63:0] w);
        int cnt;
        cnt = 0;
        key_ready  = 1'b0;
        word       = w;
        word_valid = 1'b1;
        while (word_ready !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt >= 40) begin
            n_fail++;
            $display("FAIL push_timeout: word_ready_o=%b required 1", word_ready);
        end
        @(negedge clk);
        word_valid = 1'b0;
        word       = {$urandom, $urandom};
    endtask

    // Sends a full key, optionally with idle gaps (junk data, stray key_ready).
    task automatic send_key(input words_t w, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    word      = {$urandom, $urandom};
                    key_ready = 1'(($urandom) & 1);
                    @(negedge clk);
                end
            end
            push_word(w[i]);
        end
    endtask

    task automatic consume();
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; word = '0; word_valid = 1'b0; key_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (key[1023:0] !== '0 || key[1087:1024] !== C240) begin
            n_fail++; $display("FAIL reset_key: key_o=%h required parity %h, words 0", key, C240);
        end
        n_checks++;
        if (key_valid !== 1'b0 || word_ready !== 1'b0 || word_idx !== 5'd0) begin
            n_fail++; $display("FAIL reset_ctrl: valid=%b ready=%b idx=%0d required 0 0 0", key_valid, word_ready, word_idx);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (word_ready !== 1'b0) begin
            n_fail++; $display("FAIL idle_cycle: word_ready_o=%b required 0", word_ready);
        end
        @(negedge clk);
        n_checks++;
        if (word_ready !== 1'b1 || word_idx !== 5'd0) begin
            n_fail++; $display("FAIL fill_entry: ready=%b idx=%0d required 1 0", word_ready, word_idx);
        end
        $display("reset: done");
    endtask

    task automatic test_zero_words();
        words_t w;
        for (int i = 0; i < 16; i++) w[i] = '0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (word_idx !== 5'(i) || key_valid !== 1'b0) begin
                n_fail++; $display("FAIL zero_idx: idx=%0d valid=%b required %0d 0", word_idx, key_valid, i);
            end
            push_word(w[i]);
        end
        n_checks++;
        if (key_valid !== 1'b1 || word_ready !== 1'b0 || word_idx !== 5'd16) begin
            n_fail++; $display("FAIL zero_full: valid=%b ready=%b idx=%0d required 1 0 16", key_valid, word_ready, word_idx);
        end
        n_checks++;
        if (key[1023:0] !== '0 || key[1087:1024] !== C240) begin
            n_fail++; $display("FAIL zero_key: key_o=%h required parity %h, words 0", key, C240);
        end
        consume();
        n_checks++;
        if (word_ready !== 1'b1 || key_valid !== 1'b0 || word_idx !== 5'd0) begin
            n_fail++; $display("FAIL zero_consume: ready=%b valid=%b idx=%0d required 1 0 0", word_ready, key_valid, word_idx);
        end
        $display("zero key: done");
    endtask

    task automatic test_count_words();
        words_t w;
        for (int i = 0; i < 16; i++) w[i] = 64'(i);
        send_key(w, 1'b0);
        n_checks++;
        if (key !== model_key(w) || key[1087:1024] !== C240) begin
            n_fail++; $display("FAIL count_key: key_o=%h required %h", key, model_key(w));
        end
        consume();
        $display("count key: done");
    endtask

    task automatic test_ones_word();
        words_t w;
        for (int i = 0; i < 16; i++) w[i] = '0;
        w[0] = '1;
        send_key(w, 1'b0);
        n_checks++;
        if (key[63:0] !== 64'hFFFFFFFFFFFFFFFF || key[1087:1024] !== 64'hE42EE4255603E5DD) begin
            n_fail++; $display("FAIL ones_key: word0=%h parity=%h required all ones and e42ee4255603e5dd", key[63:0], key[1087:1024]);
        end
        $display("ones key: done");
    endtask

    // Entered while FULL from the previous test.
    task automatic test_hold_full();
        logic [1087:0] held;
        held       = key;
        word       = 64'hDEADBEEF01234567;
        word_valid = 1'b1;
        key_ready  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (word_ready !== 1'b0 || key_valid !== 1'b1 || key !== held) begin
                n_fail++; $display("FAIL hold_full: ready=%b valid=%b key_o=%h required 0 1 %h", word_ready, key_valid, key, held);
            end
        end
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        n_checks++;
        if (word_ready !== 1'b1 || word_idx !== 5'd0 || key_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: ready=%b idx=%0d valid=%b required 1 0 0", word_ready, word_idx, key_valid);
        end
        @(negedge clk);
        word_valid = 1'b0;
        n_checks++;
        if (word_idx !== 5'd1 || key[63:0] !== 64'hDEADBEEF01234567) begin
            n_fail++; $display("FAIL hold_first_accept: idx=%0d word0=%h required 1 deadbeef01234567", word_idx, key[63:0]);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (word_idx !== 5'd0 || word_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_clear: idx=%0d ready=%b required 0 1", word_idx, word_ready);
        end
        $display("hold full: done");
    endtask

    task automatic test_clear();
        words_t junk, a5;
        junk = rand_words();
        for (int i = 0; i < 7; i++) push_word(junk[i]);
        n_checks++;
        if (word_idx !== 5'd7) begin
            n_fail++; $display("FAIL clear_pre: idx=%0d required 7", word_idx);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (word_idx !== 5'd0 || key_valid !== 1'b0 || word_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_post: idx=%0d valid=%b ready=%b required 0 0 1", word_idx, key_valid, word_ready);
        end
        for (int i = 0; i < 16; i++) a5[i] = 64'hA5A5A5A5A5A5A5A5;
        send_key(a5, 1'b1);
        n_checks++;
        if (key !== model_key(a5) || key[1087:1024] !== C240 || key_valid !== 1'b1) begin
            n_fail++; $display("FAIL clear_refill: key_o=%h valid=%b required %h 1", key, key_valid, model_key(a5));
        end
        consume();
        $display("clear mid-fill: done");
    endtask

    task automatic test_clear_edges();
        words_t w;
        w = rand_words();
        for (int i = 0; i < 15; i++) push_word(w[i]);
        word = w[15]; word_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        word_valid = 1'b0; clear = 1'b0;
        n_checks++;
        if (key_valid !== 1'b0 || word_idx !== 5'd0 || word_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_last_edge: valid=%b idx=%0d ready=%b required 0 0 1", key_valid, word_idx, word_ready);
        end
        w = rand_words();
        send_key(w, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (key_valid !== 1'b0 || word_idx !== 5'd0 || word_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear_full: valid=%b idx=%0d ready=%b required 0 0 1", key_valid, word_idx, word_ready);
        end
        $display("clear edges: done");
    endtask

    task automatic test_reset_midfill();
        words_t w;
        w = rand_words();
        for (int i = 0; i < 9; i++) push_word(w[i]);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (key_valid !== 1'b0 || word_ready !== 1'b0 || word_idx !== 5'd0 || key[1023:0] !== '0) begin
            n_fail++; $display("FAIL midfill_reset: valid=%b ready=%b idx=%0d low_nonzero=%b required 0 0 0 0", key_valid, word_ready, word_idx, |key[1023:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (word_ready !== 1'b0) begin
            n_fail++; $display("FAIL midfill_idle: word_ready_o=%b required 0", word_ready);
        end
        @(negedge clk);
        w = rand_words();
        send_key(w, 1'b1);
        n_checks++;
        if (key !== model_key(w) || key_valid !== 1'b1) begin
            n_fail++; $display("FAIL midfill_refill: key_o=%h required %h", key, model_key(w));
        end
        consume();
        $display("reset mid-fill: done");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            words_t w;
            int d;
            w = rand_words();
            send_key(w, (k % 2) == 1);
            n_checks++;
            if (key !== model_key(w) || key_valid !== 1'b1) begin
                n_fail++; $display("FAIL b2b_key%0d: key_o=%h required %h", k, key, model_key(w));
            end
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            n_checks++;
            if (key !== model_key(w) || key_valid !== 1'b1) begin
                n_fail++; $display("FAIL b2b_stable%0d: key_o=%h required %h", k, key, model_key(w));
            end
            consume();
            $display("key %0d: parity=%h consumed after %0d waits", k, model_key(w) >> 1024, d);
        end
    endtask

    initial begin
        test_reset();
        test_zero_words();
        test_count_words();
        test_ones_word();
        test_hold_full();
        test_clear();
        test_clear_edges();
        test_reset_midfill();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
